// File: rtl/run_length_checker.sv
// run_length_checker
//   Consumes the sampled output of the 1,2,2,3,3,3,...,MAXV staircase counter.
//   Consecutive equal samples are folded into (value, run-length) tokens. Every
//   closed run is checked: value v must repeat exactly v samples, and values must
//   step 1..MAXV and then wrap to 1. Tokens are queued in a small FIFO and handed to
//   the consumer over a valid/ready interface.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, clears run, FIFO and statistics
//   in_valid   in_data carries a sample this cycle (no backpressure on input)
//   in_data    counter value
//   flush      close the current run immediately (end of capture)
//   out_valid  FIFO holds at least one token
//   out_ready  consumer takes the head token when out_valid is also high
//   out_value  run value of the head token
//   out_len    run length of the head token (saturating)
//   out_err    head token failed the length or sequence check
//   overflow   sticky flag: a token was dropped because the FIFO was full
//   err_cnt    number of closed runs with an error, saturating at 255
module run_length_checker #(
    parameter int W     = 3,
    parameter int LW    = 4,
    parameter int DEPTH = 4,
    parameter int MAXV  = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_value,
    output logic [LW-1:0] out_len,
    output logic          out_err,
    output logic          overflow,
    output logic [7:0]    err_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = W + LW + 1;

    localparam logic [LW-1:0] LEN_ONE   = LW'(1);
    localparam logic [LW-1:0] LEN_MAX   = {LW{1'b1}};
    localparam logic [W-1:0]  VAL_ONE   = W'(1);
    localparam logic [W-1:0]  VAL_MAX   = W'(MAXV);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO  = '0;
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [7:0]    ERR_MAX   = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A run is bad if its length differs from its value or the value is out of order.
    // A saturated length (all ones) can never equal a W-bit value, so it always errs.
    function automatic logic run_err(input logic [W-1:0]  val,
                                     input logic [LW-1:0] len,
                                     input logic [W-1:0]  expv);
        return (LW'(val) != len) || (val != expv);
    endfunction

    // Next expected value follows the observed value so a single bad run does not
    // flag every run after it.
    function automatic logic [W-1:0] next_expected(input logic [W-1:0] val);
        return (val == VAL_MAX) ? VAL_ONE : (val + VAL_ONE);
    endfunction

    state_t          state_r, state_nxt_s;
    logic [W-1:0]    cur_val_r, cur_val_nxt_s;
    logic [LW-1:0]   cur_len_r, cur_len_nxt_s;
    logic [W-1:0]    expected_r;
    logic            close_s;
    logic            close_err_s;

    logic [TW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            overflow_r;
    logic [7:0]      err_cnt_r;

    logic            pop_s;
    logic            full_s;
    logic            push_s;
    logic            drop_s;
    logic [TW-1:0]   head_s;

    // Run tracking: next-state, run value/length and the close strobe.
    always_comb begin
        state_nxt_s   = state_r;
        cur_val_nxt_s = cur_val_r;
        cur_len_nxt_s = cur_len_r;
        close_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s   = ST_RUN;
                    cur_val_nxt_s = in_data;
                    cur_len_nxt_s = LEN_ONE;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    // Any sample arriving with flush is discarded.
                    close_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (in_valid && (in_data == cur_val_r)) begin
                    if (cur_len_r != LEN_MAX) begin
                        cur_len_nxt_s = cur_len_r + LEN_ONE;
                    end else begin
                        cur_len_nxt_s = cur_len_r;
                    end
                end else if (in_valid) begin
                    close_s       = 1'b1;
                    cur_val_nxt_s = in_data;
                    cur_len_nxt_s = LEN_ONE;
                end else begin
                    // Gaps hold the run open.
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign close_err_s = run_err(cur_val_r, cur_len_r, expected_r);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    // when the consumer is draining it.
    assign pop_s  = (count_r != CNT_ZERO) && out_ready;
    assign full_s = (count_r == CNT_FULL);
    assign push_s = close_s && (!full_s || pop_s);
    assign drop_s = close_s && full_s && !pop_s;
    assign head_s = mem_r[rd_ptr_r];

    // Run state, sequence expectation and error statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cur_val_r  <= '0;
            cur_len_r  <= '0;
            expected_r <= VAL_ONE;
            err_cnt_r  <= 8'd0;
            overflow_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cur_val_r <= cur_val_nxt_s;
            cur_len_r <= cur_len_nxt_s;
            if (close_s) begin
                expected_r <= next_expected(cur_val_r);
                if (close_err_s && (err_cnt_r != ERR_MAX)) begin
                    err_cnt_r <= err_cnt_r + 8'd1;
                end
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Token FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {cur_val_r, cur_len_r, close_err_s};
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign out_valid = (count_r != CNT_ZERO);
    assign out_value = head_s[TW-1 -: W];
    assign out_len   = head_s[LW:1];
    assign out_err   = head_s[0];
    assign overflow  = overflow_r;
    assign err_cnt   = err_cnt_r;

endmodule
